eth_sw_rd_arbiter: RTL
======================

# eth_sw_rd_arbiter

Packet-level round-robin read scheduler for the two ingress port FIFOs of the 2x2 Ethernet switch. It sits between the port FIFOs and the switch output stage. It generates the per-port `rd_en` so that exactly one FIFO is drained at a time, and it holds each grant from SOP to EOP so packets never interleave. It also drops stray non-SOP words, aborts runaway packets, and keeps per-port packet statistics.

## Interface
- `PORT_COUNT`, 2: number of ingress FIFOs. Fixed at 2 in this revision.
- `MAX_PKT_WORDS`, 64: maximum words per packet before abort. Range 2..255.
- `CNT_WIDTH`, 16: width of the statistics counters.

- `clk`  in  1  clock
- `rstn`  in  1  reset; synchronous, active-low
- `fifo_empty`  in  [PORT_COUNT]  per-port FIFO empty flag
- `fifo_sop`  in  [PORT_COUNT]  SOP flag of the FIFO head word (head bit 0)
- `fifo_eop`  in  [PORT_COUNT]  EOP flag of the FIFO head word (head bit 129)
- `out_ready`  in  1  output stage can accept a word this cycle
- `rd_en`  out  [PORT_COUNT]  pop strobe per FIFO; at most one bit high
- `grant_valid`  out  1  a packet burst is in progress
- `grant_id`  out  1  port currently or last granted
- `drop_pulse`  out  1  one-cycle pulse when a stray non-SOP head word is discarded
- `timeout_pulse`  out  1  one-cycle pulse when a packet exceeds `MAX_PKT_WORDS`
- `pkt_cnt`  out  [PORT_COUNT][CNT_WIDTH]  completed packets per port

## Operation
- FIFO heads are show-ahead: the head word and its flags are valid whenever `fifo_empty[p]`=0. `rd_en[p]` pops that word at the next clock edge.
- A port requests when `req[p] = ~fifo_empty[p] & fifo_sop[p]`.
- FSM states:
  - IDLE
    - If at least one port requests, grant one and go to BURST.
    - If no port requests but a non-empty port has `fifo_sop=0`, go to FLUSH for that port, taking the lowest index first.
    - Otherwise stay in IDLE.
  - BURST
    - `rd_en[g] = ~fifo_empty[g] & out_ready`.
    - Each popped word increments `word_cnt` (8-bit).
    - A pop with `fifo_eop[g]`=1 increments `pkt_cnt[g]` (wraps at 2^CNT_WIDTH) and returns to IDLE.
    - If a pop without EOP brings `word_cnt` to `MAX_PKT_WORDS`, pulse `timeout_pulse` and return to IDLE. `pkt_cnt` is not incremented.
    - An empty FIFO or `out_ready`=0 stalls the burst: no pop, grant held, `word_cnt` unchanged.
  - FLUSH
    - `rd_en[f]` is asserted for exactly one cycle regardless of `out_ready`, and `drop_pulse` is raised in the same cycle.
    - Then return to IDLE.
- Round-robin rule: when both ports request, grant the port not equal to `last_grant`. When only one requests, grant it. `last_grant` updates on entry to BURST.
- `word_cnt` clears on entry to BURST.
- A SOP word seen mid-burst is treated as data. Only EOP or timeout ends a burst.
- Invariant: `rd_en` is never 2'b11. `rd_en` is 0 in IDLE.
- `grant_valid` = (state == BURST). `grant_id` = `last_grant`.

## Timing
- Reset (rstn=0 at a clock edge) sets:
  - state IDLE, `last_grant`=1 (so port 0 wins the first tie), `grant_id`=1, `word_cnt`=0
  - `grant_valid`=0, `drop_pulse`=0, `timeout_pulse`=0, all `pkt_cnt`=0
- `rd_en` is forced to 0 while rstn=0. Reset mid-burst abandons the packet without pulses.
- Arbitration latency: a request seen in IDLE at edge N gives BURST from cycle N+1. The first `rd_en` can be in cycle N+1.
- `rd_en` is combinational from the registered state, `fifo_empty` and `out_ready`. All other outputs are registered.
- EOP popped at edge M: IDLE at M+1, next grant at M+2 at the earliest. There is a one-cycle bubble between packets.
- `drop_pulse` is combinational with the FLUSH pop. `timeout_pulse` is registered, high in the cycle after the offending pop.
- Packet of L words with no stalls: occupies L BURST cycles plus 1 IDLE cycle.

## Structure
- Shared package `eth_sw_pkg`:
  - arbiter state enum (IDLE/BURST/FLUSH)
  - `PORT_COUNT`
  - FIFO head bit positions (SOP=0, EOP=129)
- One sub-module, `eth_sw_rr_pick`: a combinational 2-way round-robin picker with inputs `req` and `last_grant` and outputs `pick_valid` and `pick_id`. Everything else (FSM, counters) lives in the top of the block.

## Test plan
- Port 0 holds a 4-word packet (SOP on word 0, EOP on word 3), port 1 empty, `out_ready`=1 → `rd_en`=01 for 4 consecutive cycles, `pkt_cnt[0]`=1, `grant_valid` drops the cycle after EOP.
- Both ports hold 3-word packets from reset → port 0 is served first, then port 1 after the 1-cycle bubble. `rd_en` never reads 11, and both `pkt_cnt` end at 1.
- Port 1 burst with `out_ready` low for 5 cycles mid-packet → no pops during the stall, grant held, the remaining words are popped after release, and `word_cnt` is correct.
- Port 0 head word has SOP=0 → FLUSH asserts `rd_en[0]` for 1 cycle with `drop_pulse`=1, and the following SOP packet is granted normally.
- `MAX_PKT_WORDS`=8 and a packet with no EOP → exactly 8 pops, `timeout_pulse` high one cycle, `pkt_cnt` unchanged, return to IDLE.
- Assert rstn=0 on the 2nd word of a burst → next cycle `rd_en`=0, state IDLE, all counters 0, and port 0 wins the next tie.

Source files
------------

// File: rtl/eth_sw_pkg.sv
// Shared definitions for the 2x2 Ethernet switch datapath.
//   PORT_COUNT      : number of ingress port FIFOs
//   HEAD_*_BIT      : flag positions inside a 130-bit FIFO head word
//   WORD_CNT_WIDTH  : width of the per-packet word counter
//   arb_state_e     : read-arbiter FSM encoding
package eth_sw_pkg;

    localparam int unsigned PORT_COUNT     = 2;
    localparam int unsigned HEAD_WIDTH     = 130;
    localparam int unsigned HEAD_SOP_BIT   = 0;
    localparam int unsigned HEAD_EOP_BIT   = 129;
    localparam int unsigned WORD_CNT_WIDTH = 8;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_BURST = 2'd1,
        ARB_FLUSH = 2'd2
    } arb_state_e;

endpackage

// File: rtl/eth_sw_rr_pick.sv
// Combinational two-way round-robin picker.
//   req        : per-port request vector
//   last_grant : port granted most recently
//   pick_valid : at least one port requests
//   pick_id    : chosen port (the one not last granted when both request)
module eth_sw_rr_pick
    import eth_sw_pkg::*;
(
    input  logic [PORT_COUNT-1:0] req,
    input  logic                  last_grant,
    output logic                  pick_valid,
    output logic                  pick_id
);

    // Tie goes to the port that did not win last time.
    always_comb begin
        pick_valid = |req;
        pick_id    = 1'b0;
        if (req[0] && req[1]) begin
            pick_id = ~last_grant;
        end else if (req[1]) begin
            pick_id = 1'b1;
        end
    end

endmodule

// File: rtl/eth_sw_rd_arbiter.sv
// Packet-level round-robin read scheduler for the two ingress FIFOs.
// Holds a grant from SOP to EOP, discards stray non-SOP head words,
// aborts packets longer than MAX_PKT_WORDS and counts completed packets.
//   clk, rstn     : clock, synchronous active-low reset
//   fifo_empty    : per-port FIFO empty flag
//   fifo_sop/eop  : flags of the show-ahead head word
//   out_ready     : output stage accepts a word this cycle
//   rd_en         : per-port pop strobe (combinational, at most one high)
//   grant_valid   : a packet burst is in progress
//   grant_id      : port currently or last granted
//   drop_pulse    : stray head word discarded this cycle (combinational)
//   timeout_pulse : packet aborted at the previous pop
//   pkt_cnt       : completed packets per port
module eth_sw_rd_arbiter
    import eth_sw_pkg::*;
#(
    parameter int unsigned MAX_PKT_WORDS = 64,
    parameter int unsigned CNT_WIDTH     = 16
)(
    input  logic                                  clk,
    input  logic                                  rstn,
    input  logic [PORT_COUNT-1:0]                 fifo_empty,
    input  logic [PORT_COUNT-1:0]                 fifo_sop,
    input  logic [PORT_COUNT-1:0]                 fifo_eop,
    input  logic                                  out_ready,
    output logic [PORT_COUNT-1:0]                 rd_en,
    output logic                                  grant_valid,
    output logic                                  grant_id,
    output logic                                  drop_pulse,
    output logic                                  timeout_pulse,
    output logic [PORT_COUNT-1:0][CNT_WIDTH-1:0]  pkt_cnt
);

    localparam logic [1:0] ST_IDLE  = 2'(ARB_IDLE);
    localparam logic [1:0] ST_BURST = 2'(ARB_BURST);
    localparam logic [1:0] ST_FLUSH = 2'(ARB_FLUSH);

    localparam logic [WORD_CNT_WIDTH-1:0] MAX_WORDS = WORD_CNT_WIDTH'(MAX_PKT_WORDS);

    logic [1:0]                          state_q, state_d;
    logic                                last_grant_q, last_grant_d;
    logic                                flush_id_q, flush_id_d;
    logic [WORD_CNT_WIDTH-1:0]           word_cnt_q, word_cnt_d;
    logic                                timeout_q, timeout_d;
    logic [PORT_COUNT-1:0][CNT_WIDTH-1:0] pkt_cnt_q, pkt_cnt_d;

    logic [PORT_COUNT-1:0]     req;
    logic [PORT_COUNT-1:0]     stray;
    logic                      pick_valid;
    logic                      pick_id;
    logic [PORT_COUNT-1:0]     rd_en_c;
    logic                      drop_c;
    logic [WORD_CNT_WIDTH-1:0] word_cnt_inc;

    // A head word is a request only if it starts a packet; otherwise it is stray.
    assign req   = ~fifo_empty & fifo_sop;
    assign stray = ~fifo_empty & ~fifo_sop;

    assign word_cnt_inc = word_cnt_q + WORD_CNT_WIDTH'(1);

    eth_sw_rr_pick u_rr_pick (
        .req        (req),
        .last_grant (last_grant_q),
        .pick_valid (pick_valid),
        .pick_id    (pick_id)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q      <= ST_IDLE;
            last_grant_q <= 1'b1;
            flush_id_q   <= 1'b0;
            word_cnt_q   <= '0;
            timeout_q    <= 1'b0;
            pkt_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            flush_id_q   <= flush_id_d;
            word_cnt_q   <= word_cnt_d;
            timeout_q    <= timeout_d;
            pkt_cnt_q    <= pkt_cnt_d;
        end
    end

    // Next-state, pop strobes and counter updates.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        flush_id_d   = flush_id_q;
        word_cnt_d   = word_cnt_q;
        timeout_d    = 1'b0;
        pkt_cnt_d    = pkt_cnt_q;
        rd_en_c      = '0;
        drop_c       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    state_d      = ST_BURST;
                    last_grant_d = pick_id;
                    word_cnt_d   = '0;
                end else if (stray[0]) begin
                    state_d    = ST_FLUSH;
                    flush_id_d = 1'b0;
                end else if (stray[1]) begin
                    state_d    = ST_FLUSH;
                    flush_id_d = 1'b1;
                end
            end

            ST_BURST: begin
                // Empty FIFO or back-pressure simply stalls with the grant held.
                if (!fifo_empty[last_grant_q] && out_ready) begin
                    rd_en_c[last_grant_q] = 1'b1;
                    word_cnt_d            = word_cnt_inc;
                    if (fifo_eop[last_grant_q]) begin
                        pkt_cnt_d[last_grant_q] = pkt_cnt_q[last_grant_q] + CNT_WIDTH'(1);
                        state_d                 = ST_IDLE;
                    end else if (word_cnt_inc == MAX_WORDS) begin
                        timeout_d = 1'b1;
                        state_d   = ST_IDLE;
                    end
                end
            end

            ST_FLUSH: begin
                // Discard ignores out_ready: the word never reaches the output stage.
                rd_en_c[flush_id_q] = 1'b1;
                drop_c              = 1'b1;
                state_d             = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Pops are suppressed while reset is held so a mid-burst reset loses no extra word.
    assign rd_en         = rstn ? rd_en_c : '0;
    assign drop_pulse    = rstn & drop_c;
    assign grant_valid   = (state_q == ST_BURST);
    assign grant_id      = last_grant_q;
    assign timeout_pulse = timeout_q;
    assign pkt_cnt       = pkt_cnt_q;

endmodule
